// File: rtl/ecc_pkg.sv
`default_nettype none
// =============================================================================
// ecc_pkg : shared FSM/step types and modular add/sub for GF(p) datapaths
// Revision 1.0
// =============================================================================
package ecc_pkg;

    localparam int ECC_WIDTH = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MUL_ISSUE,
        ST_MUL_WAIT,
        ST_ADDSUB,
        ST_DONE
    } state_t;

    typedef logic [3:0] step_t;

    // Operands must already be reduced below m.
    function automatic logic [ECC_WIDTH-1:0] mod_add(input logic [ECC_WIDTH-1:0] u,
                                                     input logic [ECC_WIDTH-1:0] v,
                                                     input logic [ECC_WIDTH-1:0] m);
        logic [ECC_WIDTH:0] s;
        s = {1'b0, u} + {1'b0, v};
        if (s >= {1'b0, m}) s = s - {1'b0, m};
        return s[ECC_WIDTH-1:0];
    endfunction

    function automatic logic [ECC_WIDTH-1:0] mod_sub(input logic [ECC_WIDTH-1:0] u,
                                                     input logic [ECC_WIDTH-1:0] v,
                                                     input logic [ECC_WIDTH-1:0] m);
        logic [ECC_WIDTH-1:0] d;
        d = u - v;
        if (u < v) d = d + m;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mod_mul_seq.sv
`default_nettype none
// =============================================================================
// mod_mul_seq : MSB-first interleaved shift-add modular multiplier, MUL_LAT cycles
// Revision 1.0
// =============================================================================
module mod_mul_seq
    import ecc_pkg::*;
#(
    parameter int WIDTH   = ECC_WIDTH,
    parameter int MUL_LAT = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CW = $clog2(MUL_LAT + 1);

    logic [WIDTH-1:0]   acc_q, acc_d, a_q, a_d, p_q, p_d;
    logic [MUL_LAT-1:0] b_q, b_d, b_ext;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               run_q, run_d, done_q, done_d;

    function automatic logic [WIDTH-1:0] fadd(input logic [WIDTH-1:0] u,
                                              input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] m);
        return WIDTH'(mod_add(ECC_WIDTH'(u), ECC_WIDTH'(v), ECC_WIDTH'(m)));
    endfunction

    // b is zero-extended to MUL_LAT bits; leading zeros only double a zero accumulator.
    always_comb begin
        b_ext  = MUL_LAT'(op_b);
        acc_d  = acc_q;
        a_d    = a_q;
        p_d    = p_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            a_d    = op_a;
            p_d    = modulus;
            acc_d  = b_ext[MUL_LAT-1] ? op_a : '0;
            b_d    = b_ext << 1;
            cnt_d  = CW'(MUL_LAT - 1);
            run_d  = (MUL_LAT > 1);
            done_d = (MUL_LAT == 1);
        end else if (run_q) begin
            acc_d = fadd(acc_q, acc_q, p_q);
            if (b_q[MUL_LAT-1]) acc_d = fadd(acc_d, a_q, p_q);
            b_d   = b_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            p_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            p_q    <= p_d;
            b_q    <= b_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign product = acc_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: rtl/jacob_point_double.sv
`default_nettype none
// =============================================================================
// jacob_point_double : Jacobian point doubling over GF(p) with one shared
// sequential multiplier. Option macro A_MINUS3_EN selects the a = p-3 schedule.
// Revision 1.0
// =============================================================================
module jacob_point_double
    import ecc_pkg::*;
#(
    parameter int WIDTH   = ECC_WIDTH,
    parameter int MUL_LAT = WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] z1,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] p,
    input  logic             flag_input,
    output logic             busy,
    output logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] y3,
    output logic [WIDTH-1:0] z3,
    output logic             flag_output
);

    typedef enum logic [3:0] {
        OP_YY, OP_S, OP_XX, OP_ZZ, OP_Z4, OP_M, OP_X3, OP_Y4, OP_Y3, OP_Z3
    } op_t;

`ifdef A_MINUS3_EN
    localparam int N_MUL = 8;
`else
    localparam int N_MUL = 10;
`endif
    localparam step_t LAST_STEP = step_t'(N_MUL - 1);

    function automatic op_t step_op(input step_t s);
`ifdef A_MINUS3_EN
        case (s)
            4'd0:    return OP_YY;
            4'd1:    return OP_S;
            4'd2:    return OP_ZZ;
            4'd3:    return OP_M;
            4'd4:    return OP_X3;
            4'd5:    return OP_Y4;
            4'd6:    return OP_Y3;
            default: return OP_Z3;
        endcase
`else
        case (s)
            4'd0:    return OP_YY;
            4'd1:    return OP_S;
            4'd2:    return OP_XX;
            4'd3:    return OP_ZZ;
            4'd4:    return OP_Z4;
            4'd5:    return OP_M;
            4'd6:    return OP_X3;
            4'd7:    return OP_Y4;
            4'd8:    return OP_Y3;
            default: return OP_Z3;
        endcase
`endif
    endfunction

    function automatic logic [WIDTH-1:0] fadd(input logic [WIDTH-1:0] u,
                                              input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] m);
        return WIDTH'(mod_add(ECC_WIDTH'(u), ECC_WIDTH'(v), ECC_WIDTH'(m)));
    endfunction

    function automatic logic [WIDTH-1:0] fsub(input logic [WIDTH-1:0] u,
                                              input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] m);
        return WIDTH'(mod_sub(ECC_WIDTH'(u), ECC_WIDTH'(v), ECC_WIDTH'(m)));
    endfunction

    state_t           state_q, state_d;
    step_t            step_q, step_d;
    logic             busy_q, busy_d, flag_q, flag_d, mul_start_q, mul_start_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d, a_q, a_d, p_q, p_d;
    logic [WIDTH-1:0] prod_q, prod_d, yy_q, yy_d, s_q, s_d, xx_q, xx_d;
    logic [WIDTH-1:0] zz_q, zz_d, z4_q, z4_d, m_q, m_d, t_q, t_d, y4_q, y4_d;
    logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d, rz_q, rz_d;
    logic [WIDTH-1:0] x3_q, x3_d, y3_q, y3_d, z3_q, z3_d;
    logic [WIDTH-1:0] mul_a, mul_b, mul_product, x3_new;
    logic             mul_done;
    op_t              op;

    assign op = step_op(step_q);

    // Operands stay stable through MUL_WAIT because step_q only moves in ADDSUB.
    always_comb begin
        mul_a = y_q;
        mul_b = z_q;
        case (op)
            OP_YY:   begin mul_a = y_q;  mul_b = y_q;  end
            OP_S:    begin mul_a = x_q;  mul_b = yy_q; end
            OP_XX:   begin mul_a = x_q;  mul_b = x_q;  end
            OP_ZZ:   begin mul_a = z_q;  mul_b = z_q;  end
            OP_Z4:   begin mul_a = zz_q; mul_b = zz_q; end
`ifdef A_MINUS3_EN
            OP_M:    begin mul_a = fsub(x_q, zz_q, p_q); mul_b = fadd(x_q, zz_q, p_q); end
`else
            OP_M:    begin mul_a = a_q;  mul_b = z4_q; end
`endif
            OP_X3:   begin mul_a = m_q;  mul_b = m_q;  end
            OP_Y4:   begin mul_a = yy_q; mul_b = yy_q; end
            OP_Y3:   begin mul_a = m_q;  mul_b = t_q;  end
            default: begin mul_a = y_q;  mul_b = z_q;  end
        endcase
    end

    always_comb begin
        state_d = state_q;  step_d = step_q;  busy_d = busy_q;
        flag_d = 1'b0;      mul_start_d = 1'b0;
        x_d = x_q;  y_d = y_q;  z_d = z_q;  a_d = a_q;  p_d = p_q;
        prod_d = prod_q;  yy_d = yy_q;  s_d = s_q;  xx_d = xx_q;  zz_d = zz_q;
        z4_d = z4_q;  m_d = m_q;  t_d = t_q;  y4_d = y4_q;
        rx_d = rx_q;  ry_d = ry_q;  rz_d = rz_q;
        x3_d = x3_q;  y3_d = y3_q;  z3_d = z3_q;
        x3_new = fsub(prod_q, fadd(s_q, s_q, p_q), p_q);
        case (state_q)
            ST_IDLE: if (flag_input) begin
                x_d = x1;  y_d = y1;  z_d = z1;  a_d = a;  p_d = p;
                busy_d  = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: if (z_q == '0 || y_q == '0) begin
                rx_d = WIDTH'(1);  ry_d = WIDTH'(1);  rz_d = '0;
                state_d = ST_DONE;
            end else begin
                step_d  = '0;
                state_d = ST_MUL_ISSUE;
            end
            ST_MUL_ISSUE: begin
                mul_start_d = 1'b1;
                state_d     = ST_MUL_WAIT;
            end
            ST_MUL_WAIT: if (mul_done) begin
                prod_d  = mul_product;
                state_d = ST_ADDSUB;
            end
            ST_ADDSUB: begin
                case (op)
                    OP_YY: yy_d = prod_q;
                    OP_S:  s_d  = fadd(fadd(prod_q, prod_q, p_q), fadd(prod_q, prod_q, p_q), p_q);
                    OP_XX: xx_d = prod_q;
                    OP_ZZ: zz_d = prod_q;
                    OP_Z4: z4_d = prod_q;
`ifdef A_MINUS3_EN
                    OP_M:  m_d  = fadd(fadd(prod_q, prod_q, p_q), prod_q, p_q);
`else
                    OP_M:  m_d  = fadd(fadd(fadd(xx_q, xx_q, p_q), xx_q, p_q), prod_q, p_q);
`endif
                    OP_X3: begin
                        rx_d = x3_new;
                        t_d  = fsub(s_q, x3_new, p_q);
                    end
                    OP_Y4: y4_d = prod_q;
                    OP_Y3: ry_d = fsub(prod_q,
                                  fadd(fadd(fadd(y4_q, y4_q, p_q), fadd(y4_q, y4_q, p_q), p_q),
                                       fadd(fadd(y4_q, y4_q, p_q), fadd(y4_q, y4_q, p_q), p_q), p_q),
                                  p_q);
                    default: rz_d = fadd(prod_q, prod_q, p_q);
                endcase
                if (step_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end else begin
                    step_d  = step_q + step_t'(1);
                    state_d = ST_MUL_ISSUE;
                end
            end
            ST_DONE: begin
                x3_d = rx_q;  y3_d = ry_q;  z3_d = rz_q;
                flag_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;  step_q <= '0;  busy_q <= 1'b0;
            flag_q  <= 1'b0;     mul_start_q <= 1'b0;
            x_q <= '0;  y_q <= '0;  z_q <= '0;  a_q <= '0;  p_q <= '0;
            prod_q <= '0;  yy_q <= '0;  s_q <= '0;  xx_q <= '0;  zz_q <= '0;
            z4_q <= '0;  m_q <= '0;  t_q <= '0;  y4_q <= '0;
            rx_q <= '0;  ry_q <= '0;  rz_q <= '0;
            x3_q <= '0;  y3_q <= '0;  z3_q <= '0;
        end else begin
            state_q <= state_d;  step_q <= step_d;  busy_q <= busy_d;
            flag_q  <= flag_d;   mul_start_q <= mul_start_d;
            x_q <= x_d;  y_q <= y_d;  z_q <= z_d;  a_q <= a_d;  p_q <= p_d;
            prod_q <= prod_d;  yy_q <= yy_d;  s_q <= s_d;  xx_q <= xx_d;  zz_q <= zz_d;
            z4_q <= z4_d;  m_q <= m_d;  t_q <= t_d;  y4_q <= y4_d;
            rx_q <= rx_d;  ry_q <= ry_d;  rz_q <= rz_d;
            x3_q <= x3_d;  y3_q <= y3_d;  z3_q <= z3_d;
        end
    end

    mod_mul_seq #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start_q),
        .op_a    (mul_a),
        .op_b    (mul_b),
        .modulus (p_q),
        .product (mul_product),
        .done    (mul_done)
    );

    assign busy        = busy_q;
    assign flag_output = flag_q;
    assign x3          = x3_q;
    assign y3          = y3_q;
    assign z3          = z3_q;

endmodule
`default_nettype wire

// File: tb/tb_jacob_point_double.sv
`default_nettype none
// =============================================================================
// tb_jacob_point_double : scoreboard bench for jacob_point_double
// Revision 1.0
// =============================================================================
module tb_jacob_point_double;

    localparam int WIDTH   = 256;
    localparam int MUL_LAT = 256;
`ifdef A_MINUS3_EN
    localparam int N_MUL = 8;
`else
    localparam int N_MUL = 10;
`endif
    localparam int LAT     = 3 + N_MUL * (MUL_LAT + 3);
    localparam int INF_LAT = 3;

    typedef logic [WIDTH-1:0] fe_t;
    typedef struct { fe_t x; fe_t y; fe_t z; fe_t p; int t; } exp_t;

    localparam fe_t SECP_P  = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam fe_t SECP_GX = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    localparam fe_t SECP_GY = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

    logic clk = 1'b0;
    logic rst, flag_input, busy, flag_output;
    fe_t  x1, y1, z1, a_in, p_in, x3, y3, z3;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    jacob_point_double #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk), .rst (rst), .x1 (x1), .y1 (y1), .z1 (z1), .a (a_in), .p (p_in),
        .flag_input (flag_input), .busy (busy), .x3 (x3), .y3 (y3), .z3 (z3),
        .flag_output (flag_output)
    );

    // Reference arithmetic: full-width products reduced with %.
    function automatic fe_t fmul(input fe_t u, input fe_t v, input fe_t m);
        logic [2*WIDTH-1:0] w;
        w = {{WIDTH{1'b0}}, u} * {{WIDTH{1'b0}}, v};
        w = w % {{WIDTH{1'b0}}, m};
        return w[WIDTH-1:0];
    endfunction

    function automatic fe_t fadd(input fe_t u, input fe_t v, input fe_t m);
        logic [WIDTH:0] w;
        w = ({1'b0, u} + {1'b0, v}) % {1'b0, m};
        return w[WIDTH-1:0];
    endfunction

    function automatic fe_t fsub(input fe_t u, input fe_t v, input fe_t m);
        logic [WIDTH:0] w;
        w = ({1'b0, u} + {1'b0, m} - {1'b0, v}) % {1'b0, m};
        return w[WIDTH-1:0];
    endfunction

    task automatic model(input fe_t x, input fe_t y, input fe_t z, input fe_t a, input fe_t m,
                         output fe_t ex, output fe_t ey, output fe_t ez);
        fe_t yy, s, zz, mm;
        if (y == '0 || z == '0) begin
            ex = fe_t'(1); ey = fe_t'(1); ez = '0;
            return;
        end
        yy = fmul(y, y, m);
        s  = fmul(fe_t'(4), fmul(x, yy, m), m);
        zz = fmul(z, z, m);
`ifdef A_MINUS3_EN
        mm = fmul(fe_t'(3), fmul(fsub(x, zz, m), fadd(x, zz, m), m), m);
`else
        mm = fadd(fmul(fe_t'(3), fmul(x, x, m), m), fmul(a, fmul(zz, zz, m), m), m);
`endif
        ex = fsub(fmul(mm, mm, m), fmul(fe_t'(2), s, m), m);
        ey = fsub(fmul(mm, fsub(s, ex, m), m), fmul(fe_t'(8), fmul(yy, yy, m), m), m);
        ez = fmul(fe_t'(2), fmul(y, z, m), m);
    endtask

    task automatic chk(input string name, input fe_t act, input fe_t req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic fe_t rand_fe(input fe_t m);
        fe_t r = '0;
        for (int i = 0; i < WIDTH / 32; i++) r = {r[WIDTH-33:0], 32'($urandom())};
        return r % m;
    endfunction

    task automatic start_op(input fe_t x, input fe_t y, input fe_t z, input fe_t a, input fe_t m,
                            input bit push, input fe_t ex, input fe_t ey, input fe_t ez, input int lat);
        exp_t e;
        @(negedge clk);
        x1 = x; y1 = y; z1 = z; a_in = a; p_in = m;
        flag_input = 1'b1;
        if (push) begin
            e.x = ex; e.y = ey; e.z = ez; e.p = m; e.t = cyc + lat;
            exp_q.push_back(e);
        end
        @(negedge clk);
        flag_input = 1'b0;
    endtask

    task automatic start_small(input int x, input int y, input int z, input int a, input int m,
                               input int ex, input int ey, input int ez, input int lat);
        start_op(fe_t'(x), fe_t'(y), fe_t'(z), fe_t'(a), fe_t'(m), 1'b1,
                 fe_t'(ex), fe_t'(ey), fe_t'(ez), lat);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < LAT + 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_model(input fe_t x, input fe_t y, input fe_t z, input fe_t a, input fe_t m);
        fe_t ex, ey, ez;
        model(x, y, z, a, m, ex, ey, ez);
        start_op(x, y, z, a, m, 1'b1, ex, ey, ez, (y == '0 || z == '0) ? INF_LAT : LAT);
        drain();
    endtask

    task automatic scen_main();
`ifdef A_MINUS3_EN
        start_small(1, 1, 1, 0, 23, 15, 15, 2, LAT);
`else
        start_small(3, 10, 1, 1, 23, 17, 21, 20, LAT);
`endif
    endtask

    // Monitor: every flag_output pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (flag_output) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_flag: flag_output=1 at cycle %0d, required 0", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("x3", x3, e.x);
                    chk("y3", y3, e.y);
                    chk("z3", z3, e.z);
                    chk_int("latency_cycle", cyc, e.t);
                    chk_int("outputs_below_p", int'(x3 < e.p && y3 < e.p && z3 < e.p), 1);
                    chk_int("busy_at_flag", int'(busy), 0);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flag_input = 1'b0;
        x1 = '0; y1 = '0; z1 = '0; a_in = '0; p_in = '0;
        repeat (3) @(negedge clk);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_flag", int'(flag_output), 0);
        chk("reset_x3", x3, '0);
        chk("reset_y3", y3, '0);
        chk("reset_z3", z3, '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        scen_main();
        drain();

        start_small(5, 0, 1, 1, 23, 1, 1, 0, INF_LAT);
        drain();
        start_small(5, 7, 0, 1, 23, 1, 1, 0, INF_LAT);
        drain();

        // Second start 20 cycles after the first must be ignored.
        scen_main();
        repeat (18) @(negedge clk);
        chk_int("busy_during_op", int'(busy), 1);
        start_op(fe_t'(4), fe_t'(6), fe_t'(2), fe_t'(3), fe_t'(23), 1'b0, '0, '0, '0, 0);
        drain();

        // Reset during the fourth multiply.
        scen_main();
        repeat (3 * (MUL_LAT + 3) + 60) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk_int("midrst_busy", int'(busy), 0);
        chk_int("midrst_flag", int'(flag_output), 0);
        chk("midrst_x3", x3, '0);
        chk("midrst_y3", y3, '0);
        chk("midrst_z3", z3, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT) @(negedge clk);
        chk_int("post_rst_busy", int'(busy), 0);
        scen_main();
        drain();

        run_model(SECP_GX, SECP_GY, fe_t'(1), '0, SECP_P);

        for (int i = 0; i < 6; i++)
            run_model(rand_fe(fe_t'(23)), rand_fe(fe_t'(23)), rand_fe(fe_t'(23)),
                      rand_fe(fe_t'(23)), fe_t'(23));
        for (int i = 0; i < 3; i++)
            run_model(rand_fe(SECP_P), rand_fe(SECP_P), rand_fe(SECP_P), rand_fe(SECP_P), SECP_P);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
